// File: rtl/condicionador_entradas.sv
// Input conditioner: 2-flop sync + per-channel debounce for acao/aberto/fechado, acao edge pulse, sensor fault.
// Optional macro COND_ACAO_TOGGLE_EN: acao output toggles on each debounced press (push-button mode).
module condicionador_entradas #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic sw_acao,
  input  logic sw_aberto,
  input  logic sw_fechado,
  output logic acao,
  output logic aberto,
  output logic fechado,
  output logic acao_pulse,
  output logic sensor_fault
);

  // state | meaning
  // IDLE  | synchronised input matches the accepted level, counter held at 0
  // COUNT | input differs from the accepted level, counting consecutive cycles
  typedef enum logic {IDLE, COUNT} deb_state_t;

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  // channel index: 0 = acao, 1 = aberto, 2 = fechado
  logic [2:0]       raw;
  logic [2:0]       sync1, sync2;
  logic [2:0]       stable, stable_nxt;
  deb_state_t       state [3];
  deb_state_t       state_nxt [3];
  logic [CNT_W-1:0] cnt [3];
  logic [CNT_W-1:0] cnt_nxt [3];
  logic             acao_rise;

  assign raw = {sw_fechado, sw_aberto, sw_acao};

  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < 3; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      unique case (state[i])
        IDLE: begin
          if (sync2[i] != stable[i]) begin
            cnt_nxt[i]   = CNT_W'(1);
            state_nxt[i] = COUNT;
          end else begin
            cnt_nxt[i] = '0;
          end
        end
        COUNT: begin
          if (sync2[i] == stable[i]) begin
            cnt_nxt[i]   = '0;
            state_nxt[i] = IDLE;
          end else if (cnt[i] == CNT_TC) begin
            stable_nxt[i] = sync2[i];
            cnt_nxt[i]    = '0;
            state_nxt[i]  = IDLE;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          cnt_nxt[i]   = '0;
          state_nxt[i] = IDLE;
        end
      endcase
    end
  end

  // pulse is registered alongside the level so both rise on the same edge
  assign acao_rise = ~stable[0] & stable_nxt[0];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1        <= '0;
      sync2        <= '0;
      stable       <= '0;
      acao_pulse   <= 1'b0;
      sensor_fault <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      sync1        <= raw;
      sync2        <= sync1;
      stable       <= stable_nxt;
      acao_pulse   <= acao_rise;
      sensor_fault <= stable[1] & stable[2];
      for (int i = 0; i < 3; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

`ifdef COND_ACAO_TOGGLE_EN
  logic acao_tgl;

  always_ff @(posedge CLOCK_50) begin
    if (reset) acao_tgl <= 1'b0;
    else       acao_tgl <= acao_tgl ^ acao_rise;
  end

  assign acao = acao_tgl;
`else
  assign acao = stable[0];
`endif

  assign aberto  = stable[1];
  assign fechado = stable[2];

endmodule

// File: tb/tb_condicionador_entradas.sv
// Self-checking bench for condicionador_entradas with DEBOUNCE_CYCLES=4: directed scenarios plus random bounce,
// compared against a sliding-window reference model.
module tb_condicionador_entradas;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset, sw_acao, sw_aberto, sw_fechado;
  logic acao, aberto, fechado, acao_pulse, sensor_fault;

  int checks = 0;
  int errors = 0;

  condicionador_entradas #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLOCK_50(clk), .reset(reset), .sw_acao(sw_acao), .sw_aberto(sw_aberto),
    .sw_fechado(sw_fechado), .acao(acao), .aberto(aberto), .fechado(fechado),
    .acao_pulse(acao_pulse), .sensor_fault(sensor_fault)
  );

  always #10 clk = ~clk;

  // Reference model: a level is accepted once the synchronised input has disagreed
  // with the current output for D consecutive clock edges.
  bit         m_s1 [3];
  bit         m_s2 [3];
  bit         m_out [3];
  bit [D-1:0] m_hist [3];
  int         m_fill [3];
  bit         m_pulse, m_fault, m_tgl;

  task automatic model_edge();
    bit old_out [3];
    bit s2_pre [3];
    bit raw [3];
    raw[0] = sw_acao; raw[1] = sw_aberto; raw[2] = sw_fechado;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_out[i] = 0; m_hist[i] = '0; m_fill[i] = 0;
      end
      m_pulse = 0; m_fault = 0; m_tgl = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        old_out[i] = m_out[i];
        s2_pre[i]  = m_s2[i];
        m_s2[i]    = m_s1[i];
        m_s1[i]    = raw[i];
        m_hist[i]  = {m_hist[i][D-2:0], s2_pre[i]};
        if (m_fill[i] < D) m_fill[i]++;
        if (m_fill[i] == D && m_hist[i] == {D{~old_out[i]}}) m_out[i] = s2_pre[i];
      end
      m_pulse = !old_out[0] && m_out[0];
      m_fault = old_out[1] && old_out[2];
      m_tgl   = m_tgl ^ m_pulse;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
`ifdef COND_ACAO_TOGGLE_EN
    chk("model_acao", acao, m_tgl);
`else
    chk("model_acao", acao, m_out[0]);
`endif
    chk("model_aberto", aberto, m_out[1]);
    chk("model_fechado", fechado, m_out[2]);
    chk("model_pulse", acao_pulse, m_pulse);
    chk("model_fault", sensor_fault, m_fault);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hold;
    // 1: reset with all switches high
    reset = 1; sw_acao = 1; sw_aberto = 1; sw_fechado = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_acao", acao, 1'b0);
      chk("rst_aberto", aberto, 1'b0);
      chk("rst_fechado", fechado, 1'b0);
      chk("rst_pulse", acao_pulse, 1'b0);
      chk("rst_fault", sensor_fault, 1'b0);
    end
    reset = 0;
    step();
    chk("post_rst_acao", acao, 1'b0);
    chk("post_rst_aberto", aberto, 1'b0);
    chk("post_rst_fechado", fechado, 1'b0);
    chk("post_rst_fault", sensor_fault, 1'b0);
    sw_acao = 0; sw_aberto = 0; sw_fechado = 0;
    steps(10);

    // 2: clean aberto rise, first step is edge E
    sw_aberto = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("aberto_latency", aberto, k >= 6);
      chk("aberto_no_pulse", acao_pulse, 1'b0);
    end

    // 3: bouncy acao press, last 0->1 is the first hold step
    sw_acao = 1; step(); sw_acao = 0; step();
    sw_acao = 1; step(); sw_acao = 0; step();
    sw_acao = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
`ifndef COND_ACAO_TOGGLE_EN
      chk("acao_bounce_level", acao, k >= 6);
`else
      chk("acao_bounce_tgl", acao, k >= 6);
`endif
      chk("acao_pulse_once", acao_pulse, k == 6);
    end
    sw_acao = 0;
    steps(8);

    // 4: three-cycle glitch on fechado is rejected
    sw_fechado = 1;
    for (int k = 0; k < 3; k++) begin step(); chk("glitch_fechado", fechado, 1'b0); end
    sw_fechado = 0;
    for (int k = 0; k < 8; k++) begin step(); chk("glitch_fechado", fechado, 1'b0); end

    // 5: both limit sensors high gives sensor fault
    sw_aberto = 0;
    steps(8);
    sw_aberto = 1; sw_fechado = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("both_aberto", aberto, k >= 6);
      chk("both_fechado", fechado, k >= 6);
      chk("fault_set", sensor_fault, k >= 7);
    end
    sw_fechado = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("drop_fechado", fechado, k < 6);
      chk("drop_aberto_kept", aberto, 1'b1);
      chk("fault_clear", sensor_fault, k < 7);
    end
    sw_aberto = 0;
    steps(8);

    // 6: reset at count 2 of a pending acao press
    sw_acao = 1;
    for (int k = 0; k < 4; k++) begin step(); chk("pend_acao", acao, 1'b0); end
    reset = 1;
    for (int k = 0; k < 2; k++) begin step(); chk("mid_rst_acao", acao, 1'b0); end
    reset = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("redebounce_acao", acao, k >= 6);
      chk("redebounce_pulse", acao_pulse, k == 6);
    end
    sw_acao = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
`ifdef COND_ACAO_TOGGLE_EN
      chk("tgl_release_keeps", acao, 1'b1);
`else
      chk("release_acao", acao, k < 6);
`endif
    end
`ifdef COND_ACAO_TOGGLE_EN
    sw_acao = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("tgl_second_press", acao, k < 6);
    end
    sw_acao = 0;
    steps(8);
`endif

    // 7: random bouncing on all channels with occasional reset
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(2, 0))
        0: sw_acao = ~sw_acao;
        1: sw_aberto = ~sw_aberto;
        default: sw_fechado = ~sw_fechado;
      endcase
      reset = ($urandom_range(39, 0) == 0);
      hold = ($urandom_range(1, 0) == 0) ? $urandom_range(3, 1) : $urandom_range(9, 4);
      steps(hold);
      reset = 0;
    end
    steps(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
